// File: rtl/lcd_read_controller.sv
// HD44780 read-cycle controller: single busy-flag/address or data read per
// request, with optional busy-flag polling bounded by POLL_MAX reads.
module lcd_read_controller #(
  parameter int unsigned SETUP_CYC  = 2,
  parameter int unsigned CLK_Divide = 16,
  parameter int unsigned HOLD_CYC   = 2,
  parameter int unsigned POLL_MAX   = 1000
) (
  input  logic       iCLK,
  input  logic       iRST_N,
  input  logic       iStart,
  input  logic       iRS,
  input  logic       iPoll,
  output logic [7:0] oDATA,
  output logic       oDone,
  output logic       oTimeout,
  input  logic [7:0] LCD_DATA_IN,
  output logic       LCD_RW,
  output logic       LCD_EN,
  output logic       LCD_RS
);

  localparam logic [15:0] SetupLast = 16'(SETUP_CYC - 1);
  localparam logic [15:0] EnLast    = 16'(CLK_Divide - 1);
  localparam logic [15:0] HoldLast  = 16'(HOLD_CYC - 1);
  localparam logic [15:0] PollLimit = 16'(POLL_MAX);

  typedef enum logic [2:0] {StIdle, StSetup, StEnHigh, StHold, StDone} state_e;

  state_e      state_q, state_d;
  logic [15:0] cnt_q, cnt_d;
  logic [15:0] poll_cnt_q, poll_cnt_d;
  logic        start_prev_q;
  logic        poll_q, poll_d;
  logic        rs_q, rs_d;
  logic        rw_q, rw_d;
  logic        en_q, en_d;
  logic        done_q, done_d;
  logic        timeout_q, timeout_d;
  logic [7:0]  data_q, data_d;

  logic        start_edge;
  logic [15:0] poll_next;

  assign start_edge = iStart & ~start_prev_q;
  assign poll_next  = poll_cnt_q + 16'd1;

  assign oDATA    = data_q;
  assign oDone    = done_q;
  assign oTimeout = timeout_q;
  assign LCD_RW   = rw_q;
  assign LCD_EN   = en_q;
  assign LCD_RS   = rs_q;

  // Next-state and registered-output logic for the read sequencer
  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    poll_cnt_d = poll_cnt_q;
    poll_d     = poll_q;
    rs_d       = rs_q;
    rw_d       = rw_q;
    en_d       = en_q;
    done_d     = done_q;
    timeout_d  = timeout_q;
    data_d     = data_q;

    unique case (state_q)
      StIdle, StDone: begin
        // Edges seen in any other state are dropped, not queued
        if (start_edge) begin
          poll_d     = iPoll;
          rs_d       = iRS;
          rw_d       = 1'b1;
          done_d     = 1'b0;
          timeout_d  = 1'b0;
          poll_cnt_d = '0;
          cnt_d      = '0;
          state_d    = StSetup;
        end
      end
      StSetup: begin
        if (cnt_q == SetupLast) begin
          en_d    = 1'b1;
          cnt_d   = '0;
          state_d = StEnHigh;
        end else begin
          cnt_d = cnt_q + 16'd1;
        end
      end
      StEnHigh: begin
        // Bus is stable while EN is high; sample on the falling-EN edge
        if (cnt_q == EnLast) begin
          en_d    = 1'b0;
          data_d  = LCD_DATA_IN;
          cnt_d   = '0;
          state_d = StHold;
        end else begin
          cnt_d = cnt_q + 16'd1;
        end
      end
      StHold: begin
        if (cnt_q == HoldLast) begin
          cnt_d = '0;
          if (poll_q && !rs_q && data_q[7]) begin
            poll_cnt_d = poll_next;
            if (poll_next == PollLimit) begin
              timeout_d = 1'b1;
              rw_d      = 1'b0;
              done_d    = 1'b1;
              state_d   = StDone;
            end else begin
              state_d = StSetup;
            end
          end else begin
            rw_d    = 1'b0;
            done_d  = 1'b1;
            state_d = StDone;
          end
        end else begin
          cnt_d = cnt_q + 16'd1;
        end
      end
      default: state_d = StIdle;
    endcase
  end

  // State and output registers with asynchronous reset
  always_ff @(posedge iCLK or negedge iRST_N) begin
    if (!iRST_N) begin
      state_q      <= StIdle;
      cnt_q        <= '0;
      poll_cnt_q   <= '0;
      start_prev_q <= 1'b0;
      poll_q       <= 1'b0;
      rs_q         <= 1'b0;
      rw_q         <= 1'b0;
      en_q         <= 1'b0;
      done_q       <= 1'b0;
      timeout_q    <= 1'b0;
      data_q       <= '0;
    end else begin
      state_q      <= state_d;
      cnt_q        <= cnt_d;
      poll_cnt_q   <= poll_cnt_d;
      start_prev_q <= iStart;
      poll_q       <= poll_d;
      rs_q         <= rs_d;
      rw_q         <= rw_d;
      en_q         <= en_d;
      done_q       <= done_d;
      timeout_q    <= timeout_d;
      data_q       <= data_d;
    end
  end

endmodule

// File: tb/tb_lcd_read_controller.sv
// Directed bench for lcd_read_controller: data read, busy read, polling,
// poll timeout, start filtering and asynchronous reset mid-pulse.
module tb_lcd_read_controller;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       start = 1'b0;
  logic       rs = 1'b0;
  logic       poll = 1'b0;
  logic [7:0] din = 8'h00;
  logic [7:0] data;
  logic       done, timeout, rw, en, lcd_rs;

  int checks = 0;
  int failures = 0;

  // Small poll limit so the timeout case stays short
  lcd_read_controller #(
    .SETUP_CYC (2),
    .CLK_Divide(16),
    .HOLD_CYC  (2),
    .POLL_MAX  (4)
  ) dut (
    .iCLK       (clk),
    .iRST_N     (rst_n),
    .iStart     (start),
    .iRS        (rs),
    .iPoll      (poll),
    .oDATA      (data),
    .oDone      (done),
    .oTimeout   (timeout),
    .LCD_DATA_IN(din),
    .LCD_RW     (rw),
    .LCD_EN     (en),
    .LCD_RS     (lcd_rs)
  );

  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Inputs change on the falling edge; sample j is taken after rising edge T+j.
  // Bus shows busy_byte until pulse busy_n+1, then free_byte.
  task automatic run_txn(input logic rs_i, input logic poll_i, input logic [7:0] busy_byte,
                         input logic [7:0] free_byte, input int busy_n, input bit glitch,
                         output int pulses, output int en_cycles, output int first_en,
                         output int done_at, output bit rw_low_early);
    logic prev_en;
    @(negedge clk);
    rs = rs_i;
    poll = poll_i;
    start = 1'b1;
    din = (busy_n > 0) ? busy_byte : free_byte;
    pulses = 0;
    en_cycles = 0;
    first_en = -1;
    done_at = -1;
    rw_low_early = 1'b0;
    prev_en = 1'b0;
    for (int j = 0; j < 300 && done_at < 0; j++) begin
      @(negedge clk);
      if (en && !prev_en) begin
        pulses++;
        if (first_en < 0) first_en = j;
      end
      prev_en = en;
      if (en) en_cycles++;
      if (done) done_at = j;
      else if (!rw) rw_low_early = 1'b1;
      if (j == 2) start = 1'b0;
      if (glitch && j == 4) start = 1'b1;
      if (glitch && j == 6) start = 1'b0;
      din = (pulses <= busy_n) ? busy_byte : free_byte;
    end
    start = 1'b0;
  endtask

  int pulses, en_cycles, first_en, done_at;
  bit rw_low_early;
  logic prev_en;

  initial begin
    // Reset state
    repeat (3) @(negedge clk);
    check_eq("rst_data", data, 8'h00);
    check_eq("rst_done", done, 1'b0);
    check_eq("rst_rw", rw, 1'b0);
    check_eq("rst_en", en, 1'b0);
    rst_n = 1'b1;
    repeat (2) @(negedge clk);

    // 1. Data read
    run_txn(1'b1, 1'b0, 8'h00, 8'h41, 0, 1'b0, pulses, en_cycles, first_en, done_at,
            rw_low_early);
    check_eq("t1_first_en", first_en, 2);
    check_eq("t1_en_cycles", en_cycles, 16);
    check_eq("t1_pulses", pulses, 1);
    check_eq("t1_done_at", done_at, 20);
    check_eq("t1_data", data, 8'h41);
    check_eq("t1_rw_end", rw, 1'b0);
    check_eq("t1_rw_early", rw_low_early, 1'b0);
    check_eq("t1_rs", lcd_rs, 1'b1);

    // 2. Busy read without polling: busy flag set but only one pulse
    run_txn(1'b0, 1'b0, 8'h8A, 8'h8A, 1000, 1'b0, pulses, en_cycles, first_en, done_at,
            rw_low_early);
    check_eq("t2_pulses", pulses, 1);
    check_eq("t2_data", data, 8'h8A);
    check_eq("t2_timeout", timeout, 1'b0);
    check_eq("t2_done_at", done_at, 20);
    check_eq("t2_rs", lcd_rs, 1'b0);

    // 3. Poll success after three busy reads
    run_txn(1'b0, 1'b1, 8'h85, 8'h05, 3, 1'b0, pulses, en_cycles, first_en, done_at,
            rw_low_early);
    check_eq("t3_pulses", pulses, 4);
    check_eq("t3_rw_early", rw_low_early, 1'b0);
    check_eq("t3_data", data, 8'h05);
    check_eq("t3_timeout", timeout, 1'b0);
    check_eq("t3_done_at", done_at, 80);

    // 4. Poll timeout with the bus stuck busy
    run_txn(1'b0, 1'b1, 8'hFF, 8'hFF, 1000, 1'b0, pulses, en_cycles, first_en, done_at,
            rw_low_early);
    check_eq("t4_pulses", pulses, 4);
    check_eq("t4_timeout", timeout, 1'b1);
    check_eq("t4_data", data, 8'hFF);
    check_eq("t4_done_at", done_at, 80);
    @(negedge clk);
    rs = 1'b1;
    poll = 1'b0;
    start = 1'b1;
    @(negedge clk);
    check_eq("t4_restart_timeout", timeout, 1'b0);
    check_eq("t4_restart_done", done, 1'b0);
    check_eq("t4_restart_rw", rw, 1'b1);
    start = 1'b0;
    repeat (25) @(negedge clk);
    check_eq("t4_restart_fin", done, 1'b1);

    // 5a. Start held high for 100 cycles gives one transaction
    @(negedge clk);
    din = 8'h33;
    start = 1'b1;
    pulses = 0;
    prev_en = 1'b0;
    for (int j = 0; j < 100; j++) begin
      @(negedge clk);
      if (en && !prev_en) pulses++;
      prev_en = en;
    end
    start = 1'b0;
    check_eq("t5a_pulses", pulses, 1);
    check_eq("t5a_done", done, 1'b1);

    // 5b. Second edge mid-transaction is ignored
    run_txn(1'b1, 1'b0, 8'h00, 8'h5A, 0, 1'b1, pulses, en_cycles, first_en, done_at,
            rw_low_early);
    check_eq("t5b_pulses", pulses, 1);
    check_eq("t5b_done_at", done_at, 20);
    check_eq("t5b_data", data, 8'h5A);

    // 5c. Edge in DONE starts a new transaction on that edge
    @(negedge clk);
    start = 1'b1;
    @(negedge clk);
    check_eq("t5c_done", done, 1'b0);
    check_eq("t5c_rw", rw, 1'b1);
    start = 1'b0;
    repeat (25) @(negedge clk);
    check_eq("t5c_fin", done, 1'b1);

    // 6. Asynchronous reset in the middle of an EN pulse
    @(negedge clk);
    din = 8'h11;
    start = 1'b1;
    for (int j = 0; j <= 10; j++) begin
      @(negedge clk);
      if (j == 2) start = 1'b0;
    end
    check_eq("t6_en_before", en, 1'b1);
    #2;
    rst_n = 1'b0;
    #1;
    check_eq("t6_en", en, 1'b0);
    check_eq("t6_rw", rw, 1'b0);
    check_eq("t6_done", done, 1'b0);
    check_eq("t6_data", data, 8'h00);
    @(negedge clk);
    rst_n = 1'b1;
    repeat (2) @(negedge clk);
    run_txn(1'b1, 1'b0, 8'h00, 8'h7E, 0, 1'b0, pulses, en_cycles, first_en, done_at,
            rw_low_early);
    check_eq("t6_post_data", data, 8'h7E);
    check_eq("t6_post_done_at", done_at, 20);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/lcd_read_controller.md
Name: lcd_read_controller

Overview:
Read-side companion to the HD44780 write path of the 16x2 character LCD interface. It runs one LCD read cycle per host request. The cycle is either a busy-flag/address read (RS=0) or a DDRAM/CGRAM data read (RS=1). In poll mode it repeats the busy-flag read until the busy flag clears or a poll limit is reached. It sits beside the write controller under the display driver; the top level tristates the FPGA data-bus drivers whenever LCD_RW=1.

Parameters:
SETUP_CYC, 2, cycles LCD_RS/LCD_RW are stable before LCD_EN rises (>=1)
CLK_Divide, 16, cycles LCD_EN is held high per read pulse (>=2)
HOLD_CYC, 2, cycles LCD_EN is low after the pulse before the next step (>=1)
POLL_MAX, 1000, maximum busy-flag reads per poll request (1..65535)

Ports:
iCLK  in  1  system clock
iRST_N  in  1  asynchronous active-low reset
iStart  in  1  request; a rising edge starts a transaction
iRS  in  1  register select for the request; sampled on the accepted start edge
iPoll  in  1  poll mode; sampled on the accepted start edge; has effect only when iRS=0
oDATA  out  8  byte captured from LCD
oDone  out  1  transaction complete; stays high until the next accepted start
oTimeout  out  1  poll ended with busy still set
LCD_DATA_IN  in  8  LCD data bus input
LCD_RW  out  1  1 during a transaction, 0 otherwise
LCD_EN  out  1  LCD enable strobe
LCD_RS  out  1  register select to LCD

Behaviour:
- Reset (asynchronous, immediate, valid at any point including mid-pulse): oDATA=0, oDone=0, oTimeout=0, LCD_RW=0, LCD_EN=0, LCD_RS=0, state=IDLE, all counters=0, start-edge register=0.
- Start detect: register iStart every cycle; a start edge is {prev,iStart}==2'b01. An edge is accepted only in IDLE or DONE; edges in any other state are dropped and not queued. Holding iStart high never retriggers.
- States: IDLE, SETUP, EN_HIGH, HOLD, DONE.
- Accepted edge at clock edge T: latch iRS and iPoll; clear oDone, oTimeout and the poll count; LCD_RW<=1; LCD_RS<=iRS; go to SETUP.
- SETUP: count SETUP_CYC cycles. At edge T+SETUP_CYC: LCD_EN<=1, go to EN_HIGH.
- EN_HIGH: LCD_EN stays high for exactly CLK_Divide cycles. On the edge that drops LCD_EN, capture oDATA<=LCD_DATA_IN, then go to HOLD.
- HOLD: count HOLD_CYC cycles with LCD_EN=0 and LCD_RW=1. At the end:
  - If poll mode is active (latched iPoll=1 and RS=0) and oDATA[7]=1: increment the poll count.
    - If the count equals POLL_MAX: oTimeout<=1, go to DONE.
    - Otherwise go to SETUP. LCD_RW stays 1 and the next pulse starts SETUP_CYC cycles later.
  - Otherwise go to DONE.
- DONE entry: LCD_RW<=0, oDone<=1. oDATA and oTimeout hold until the next accepted start.
- Latency with defaults: one read pulse takes 20 cycles (S+D+H), so oDone rises at edge T+20. Each extra poll iteration adds 20 cycles.
- LCD_RS is constant for the whole transaction. LCD_EN never rises while LCD_RW=0.
- Poll count is 16 bits wide and cannot overflow because of the POLL_MAX bound.
- LCD_DATA_IN is captured on exactly one edge per pulse, with no synchronizer; the HD44780 output is stable while EN is high.
- An accepted start edge in DONE begins a new transaction on the same edge: oDone falls and LCD_RW rises.

Test Plan:
1. Data read: iRS=1, LCD_DATA_IN=8'h41, start at T -> LCD_RS=1 and LCD_RW=1 from T; LCD_EN high for exactly 16 cycles starting at T+2; oDATA=8'h41; oDone=1 at T+20; LCD_RW=0 at T+20.
2. Busy read without poll: iRS=0, iPoll=0, LCD_DATA_IN=8'h8A -> exactly one EN pulse; oDATA=8'h8A; oTimeout=0; oDone at T+20.
3. Poll success: iRS=0, iPoll=1; bus reads 8'h85 on the first 3 pulses, then 8'h05 -> 4 EN pulses; LCD_RW stays 1 throughout; oDATA=8'h05; oTimeout=0; oDone at T+80.
4. Poll timeout: POLL_MAX=4, bus stuck at 8'hFF -> 4 EN pulses; oTimeout=1; oDATA=8'hFF; oDone at T+80. A new start clears oTimeout on the edge it is accepted.
5. Start filtering: iStart held high 100 cycles -> exactly one transaction. A second edge at T+5 -> ignored, still one EN pulse. An edge in DONE -> new transaction; oDone falls on that edge.
6. Reset mid-pulse: assert iRST_N=0 at T+10 -> LCD_EN=0, LCD_RW=0, oDone=0, oDATA=0 with no clock edge needed. Release reset, then start a data read with 8'h7E -> oDATA=8'h7E after 20 cycles.
